// File: rtl/mem_pkg.sv
// Shared encodings for the memory-stage access unit: FSM states, load widths,
// writeback selects and store masks.
package mem_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } mem_state_e;

    localparam logic [2:0] F3Lb  = 3'b000;
    localparam logic [2:0] F3Lh  = 3'b001;
    localparam logic [2:0] F3Lw  = 3'b010;
    localparam logic [2:0] F3Lbu = 3'b100;
    localparam logic [2:0] F3Lhu = 3'b101;

    localparam logic [1:0] SelAlu   = 2'b00;
    localparam logic [1:0] SelLoad  = 2'b01;
    localparam logic [1:0] SelPcImm = 2'b10;
    localparam logic [1:0] SelImm   = 2'b11;

    localparam logic [3:0] DweNone = 4'b0000;
    localparam logic [3:0] DweB    = 4'b0001;
    localparam logic [3:0] DweH    = 4'b0011;
    localparam logic [3:0] DweW    = 4'b1111;

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory req/ack bus; the access unit is the master, the memory the slave.
interface mem_access_unit_if;

    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ack, dmem_rdata
    );

endinterface

// File: rtl/mem_load_align.sv
// Extracts the addressed byte/halfword/word from a read word and extends it.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  func3_i,
    output logic [31:0] data_o
);

    logic [31:0] sh;

    always_comb begin
        sh = rdata_i >> {addr_lo_i, 3'b000};
        case (func3_i)
            F3Lb:    data_o = {{24{sh[7]}}, sh[7:0]};
            F3Lh:    data_o = {{16{sh[15]}}, sh[15:0]};
            F3Lbu:   data_o = {24'b0, sh[7:0]};
            F3Lhu:   data_o = {16'b0, sh[15:0]};
            default: data_o = sh;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage access unit: issues loads/stores over req/ack, stalls the pipeline
// until completion and acts as the MEM/WB register.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        mem_alu_out_in,
    input  logic [31:0]        mem_rv1_in,
    input  logic [31:0]        mem_pc_imm_in,
    input  logic [31:0]        mem_imm_in,
    input  logic [4:0]         mem_rd_in,
    input  logic [1:0]         mem_reg_in_sel_in,
    input  logic [3:0]         mem_dwe_in,
    input  logic [2:0]         mem_func3_in,
    input  logic               mem_mem_reg_in,
    input  logic               mem_reg_wr_in,
    mem_access_unit_if.master  dmem,
    output logic               stall,
    output logic [31:0]        wb_data,
    output logic [4:0]         wb_rd,
    output logic               wb_reg_wr,
    output logic               misalign_err,
    output logic               timeout_err
);

    localparam int unsigned CntW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(MAX_WAIT - 1);

    mem_state_e  state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic        req_q, req_d, we_q, we_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic        wb_reg_wr_q, wb_reg_wr_d;

    logic        access, misaligned, is_half, is_word;
    logic        stall_c, mis_c, to_c;
    logic [31:0] load_val, sel_data;

    mem_load_align u_load_align (
        .rdata_i   (dmem.dmem_rdata),
        .addr_lo_i (mem_alu_out_in[1:0]),
        .func3_i   (mem_func3_in),
        .data_o    (load_val)
    );

    assign access = mem_mem_reg_in | (mem_dwe_in != DweNone);

    // Loads take their width from func3, stores from the unshifted byte mask.
    always_comb begin
        if (mem_mem_reg_in) begin
            is_half = (mem_func3_in[1:0] == 2'b01);
            is_word = mem_func3_in[1];
        end else begin
            is_half = (mem_dwe_in == DweH);
            is_word = (mem_dwe_in == DweW);
        end
    end

    assign misaligned = (is_half & mem_alu_out_in[0]) | (is_word & (|mem_alu_out_in[1:0]));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        stall_c = 1'b0;
        mis_c   = 1'b0;
        to_c    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (access && misaligned) begin
                    mis_c = 1'b1;
                end else if (access) begin
                    stall_c = 1'b1;
                    state_d = StBusy;
                    cnt_d   = '0;
                    req_d   = 1'b1;
                    we_d    = |mem_dwe_in;
                    addr_d  = {mem_alu_out_in[31:2], 2'b00};
                    be_d    = mem_dwe_in << mem_alu_out_in[1:0];
                    wdata_d = mem_rv1_in << {mem_alu_out_in[1:0], 3'b000};
                end
            end
            StBusy: begin
                if (dmem.dmem_ack || cnt_q == CntLast) begin
                    to_c    = ~dmem.dmem_ack;
                    state_d = StIdle;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = '0;
                    be_d    = '0;
                    wdata_d = '0;
                end else begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        unique case (mem_reg_in_sel_in)
            SelAlu:   sel_data = mem_alu_out_in;
            SelLoad:  sel_data = load_val;
            SelPcImm: sel_data = mem_pc_imm_in;
            SelImm:   sel_data = mem_imm_in;
        endcase
        wb_data_d   = wb_data_q;
        wb_rd_d     = wb_rd_q;
        wb_reg_wr_d = 1'b0;
        if (!stall_c) begin
            wb_data_d   = sel_data;
            wb_rd_d     = mem_rd_in;
            wb_reg_wr_d = mem_reg_wr_in & ~mis_c & ~to_c;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            wb_data_q   <= '0;
            wb_rd_q     <= '0;
            wb_reg_wr_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            wb_data_q   <= wb_data_d;
            wb_rd_q     <= wb_rd_d;
            wb_reg_wr_q <= wb_reg_wr_d;
        end
    end

    // Combinational outputs are masked so an asserted reset releases the pipeline at once.
    assign stall        = stall_c & ~reset;
    assign misalign_err = mis_c & ~reset;
    assign timeout_err  = to_c & ~reset;

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_be    = be_q;
    assign dmem.dmem_wdata = wdata_q;
    assign wb_data         = wb_data_q;
    assign wb_rd           = wb_rd_q;
    assign wb_reg_wr       = wb_reg_wr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus a randomized
// instruction stream checked against a behavioural reference model.
module tb_mem_access_unit;
    import mem_pkg::*;

    localparam int unsigned MaxWait = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] alu, rv1, pcimm, imm;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic [3:0]  dwe;
    logic [2:0]  f3;
    logic        ld, wr;
    logic        stall, wb_reg_wr, mis, tmo;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;

    mem_access_unit_if dmem_if ();

    mem_access_unit #(.MAX_WAIT(MaxWait)) dut (
        .clk               (clk),
        .reset             (reset),
        .mem_alu_out_in    (alu),
        .mem_rv1_in        (rv1),
        .mem_pc_imm_in     (pcimm),
        .mem_imm_in        (imm),
        .mem_rd_in         (rd),
        .mem_reg_in_sel_in (sel),
        .mem_dwe_in        (dwe),
        .mem_func3_in      (f3),
        .mem_mem_reg_in    (ld),
        .mem_reg_wr_in     (wr),
        .dmem              (dmem_if),
        .stall             (stall),
        .wb_data           (wb_data),
        .wb_rd             (wb_rd),
        .wb_reg_wr         (wb_reg_wr),
        .misalign_err      (mis),
        .timeout_err       (tmo)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Observations of the most recent exec() call.
    int          o_stall, o_busy, o_mis, o_to, o_unstable;
    logic        o_req0, o_to_stall, o_clear, o_we, o_wbw;
    logic [31:0] o_addr, o_wdata, o_wbd;
    logic [3:0]  o_be;
    logic [4:0]  o_wbr;

    function automatic int unsigned ref_width(logic l, logic [2:0] f, logic [3:0] d);
        if (l) return (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
        return (d == 4'b1111) ? 4 : (d == 4'b0011) ? 2 : 1;
    endfunction

    function automatic logic [31:0] ref_load(logic [31:0] rdv, logic [31:0] a, logic [2:0] f);
        logic [31:0] w;
        w = rdv >> (8 * (a % 4));
        case (f)
            3'd0:    return 32'($signed(w[7:0]));
            3'd1:    return 32'($signed(w[15:0]));
            3'd4:    return w & 32'hFF;
            3'd5:    return w & 32'hFFFF;
            default: return w;
        endcase
    endfunction

    task automatic set_nop();
        alu = '0; rv1 = '0; pcimm = '0; imm = '0; rd = '0; sel = '0;
        dwe = '0; f3 = '0; ld = 1'b0; wr = 1'b0;
        dmem_if.dmem_ack = 1'b0;
    endtask

    // Presents one instruction just after a rising edge and plays the memory side.
    task automatic exec(input logic [31:0] a, v, p, im, input logic [4:0] r,
                        input logic [1:0] s, input logic [3:0] d, input logic [2:0] f,
                        input logic l, w, input int ack_at, input logic [31:0] rdv,
                        input logic idle_ack);
        bit done;
        done = 1'b0;
        alu = a; rv1 = v; pcimm = p; imm = im; rd = r; sel = s; dwe = d; f3 = f;
        ld = l; wr = w;
        dmem_if.dmem_ack = idle_ack;
        dmem_if.dmem_rdata = ~rdv;
        o_stall = 0; o_busy = 0; o_mis = 0; o_to = 0; o_unstable = 0; o_to_stall = 1'b0;
        @(negedge clk);
        o_req0 = dmem_if.dmem_req;
        o_stall += int'(stall);
        o_mis += int'(mis);
        for (int c = 0; c < 40 && !done; c++) begin
            @(posedge clk);
            #1;
            if (dmem_if.dmem_req) begin
                o_busy++;
                if (o_busy == 1) begin
                    o_we = dmem_if.dmem_we; o_addr = dmem_if.dmem_addr;
                    o_be = dmem_if.dmem_be; o_wdata = dmem_if.dmem_wdata;
                end else if ({dmem_if.dmem_we, dmem_if.dmem_addr, dmem_if.dmem_be,
                              dmem_if.dmem_wdata} !== {o_we, o_addr, o_be, o_wdata}) begin
                    o_unstable++;
                end
                dmem_if.dmem_ack = (o_busy == ack_at);
                dmem_if.dmem_rdata = rdv;
                @(negedge clk);
                o_stall += int'(stall);
                o_mis += int'(mis);
                if (tmo) begin
                    o_to++;
                    o_to_stall = stall;
                end
            end else begin
                done = 1'b1;
            end
        end
        o_wbd = wb_data; o_wbr = wb_rd; o_wbw = wb_reg_wr;
        o_clear = ({dmem_if.dmem_we, dmem_if.dmem_addr, dmem_if.dmem_be,
                    dmem_if.dmem_wdata} == '0);
        set_nop();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_nop();
        alu = 32'h100; ld = 1'b1; f3 = F3Lw;  // aligned load pending while in reset
        dmem_if.dmem_rdata = '0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({wb_data, wb_rd, wb_reg_wr} !== '0) begin
            n_bad++;
            $display("FAIL reset_wb got %h/%h/%b want 0", wb_data, wb_rd, wb_reg_wr);
        end
        n_cmp++;
        if (dmem_if.dmem_req !== 1'b0 || stall !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_req_stall got %b/%b want 0/0", dmem_if.dmem_req, stall);
        end
        set_nop();
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_passthrough();
        exec(32'h1234, 32'h0, 32'h0, 32'h0, 5'd5, SelAlu, DweNone, 3'd0, 1'b0, 1'b1,
             0, 32'h0, 1'b0);
        n_cmp++;
        if ({o_wbd, o_wbr, o_wbw} !== {32'h1234, 5'd5, 1'b1}) begin
            n_bad++;
            $display("FAIL pass_wb got %h/%0d/%b want 1234/5/1", o_wbd, o_wbr, o_wbw);
        end
        n_cmp++;
        if (o_stall != 0 || o_busy != 0) begin
            n_bad++;
            $display("FAIL pass_stall got stall %0d req %0d want 0/0", o_stall, o_busy);
        end
    endtask

    task automatic test_lb_quick();
        // dmem_ack driven during IDLE must be ignored.
        exec(32'h103, 32'h0, 32'h0, 32'h0, 5'd7, SelLoad, DweNone, F3Lb, 1'b1, 1'b1,
             1, 32'h80FF0000, 1'b1);
        n_cmp++;
        if (o_addr !== 32'h100 || o_we !== 1'b0) begin
            n_bad++;
            $display("FAIL lb_addr got %h we %b want 100 we 0", o_addr, o_we);
        end
        n_cmp++;
        if (o_wbd !== 32'hFFFFFF80 || o_wbw !== 1'b1 || o_wbr !== 5'd7) begin
            n_bad++;
            $display("FAIL lb_wb got %h/%b/%0d want ffffff80/1/7", o_wbd, o_wbw, o_wbr);
        end
        n_cmp++;
        if (o_stall != 1 || o_busy != 1) begin
            n_bad++;
            $display("FAIL lb_stall got stall %0d busy %0d want 1/1", o_stall, o_busy);
        end
    endtask

    task automatic test_lhu_slow();
        exec(32'h102, 32'h0, 32'h0, 32'h0, 5'd9, SelLoad, DweNone, F3Lhu, 1'b1, 1'b1,
             3, 32'hBEEF1234, 1'b0);
        n_cmp++;
        if (o_wbd !== 32'h0000BEEF) begin
            n_bad++;
            $display("FAIL lhu_data got %h want 0000beef", o_wbd);
        end
        n_cmp++;
        if (o_stall != 3 || o_busy != 3) begin
            n_bad++;
            $display("FAIL lhu_stall got stall %0d busy %0d want 3/3", o_stall, o_busy);
        end
        n_cmp++;
        if (o_unstable != 0 || o_addr !== 32'h100 || o_clear !== 1'b1) begin
            n_bad++;
            $display("FAIL lhu_bus got unstable %0d addr %h clear %b want 0/100/1",
                     o_unstable, o_addr, o_clear);
        end
    endtask

    task automatic test_sh();
        exec(32'h202, 32'h0000ABCD, 32'h0, 32'h0, 5'd0, SelAlu, DweH, 3'd0, 1'b0, 1'b0,
             1, 32'h0, 1'b0);
        n_cmp++;
        if (o_be !== 4'b1100 || o_wdata !== 32'hABCD0000 || o_we !== 1'b1) begin
            n_bad++;
            $display("FAIL sh_bus got be %b wdata %h we %b want 1100/abcd0000/1",
                     o_be, o_wdata, o_we);
        end
        n_cmp++;
        if (o_addr !== 32'h200 || o_wbw !== 1'b0) begin
            n_bad++;
            $display("FAIL sh_addr_wr got %h/%b want 200/0", o_addr, o_wbw);
        end
    endtask

    task automatic test_misaligned();
        exec(32'h301, 32'h12345678, 32'h0, 32'h0, 5'd3, SelAlu, DweW, 3'd0, 1'b0, 1'b1,
             1, 32'h0, 1'b0);
        n_cmp++;
        if (o_req0 !== 1'b0 || o_busy != 0 || o_stall != 0) begin
            n_bad++;
            $display("FAIL mis_req got req %b busy %0d stall %0d want 0/0/0",
                     o_req0, o_busy, o_stall);
        end
        n_cmp++;
        if (o_mis != 1 || o_wbw !== 1'b0) begin
            n_bad++;
            $display("FAIL mis_err got pulses %0d wr %b want 1/0", o_mis, o_wbw);
        end
    endtask

    task automatic test_timeout();
        exec(32'h400, 32'h0, 32'h0, 32'h0, 5'd4, SelLoad, DweNone, F3Lw, 1'b1, 1'b1,
             0, 32'h11223344, 1'b0);
        n_cmp++;
        if (o_busy != MaxWait || o_to != 1 || o_to_stall !== 1'b0) begin
            n_bad++;
            $display("FAIL to_pulse got req %0d pulses %0d stall %b want %0d/1/0",
                     o_busy, o_to, o_to_stall, MaxWait);
        end
        n_cmp++;
        if (o_stall != MaxWait || o_wbw !== 1'b0 || o_clear !== 1'b1) begin
            n_bad++;
            $display("FAIL to_wb got stall %0d wr %b clear %b want %0d/0/1",
                     o_stall, o_wbw, o_clear, MaxWait);
        end
        // Ack in the last allowed cycle beats the timeout.
        exec(32'h404, 32'h0, 32'h0, 32'h0, 5'd6, SelLoad, DweNone, F3Lw, 1'b1, 1'b1,
             MaxWait, 32'hCAFEF00D, 1'b0);
        n_cmp++;
        if (o_to != 0 || o_wbw !== 1'b1 || o_wbd !== 32'hCAFEF00D) begin
            n_bad++;
            $display("FAIL ack_wins got pulses %0d wr %b data %h want 0/1/cafef00d",
                     o_to, o_wbw, o_wbd);
        end
    endtask

    task automatic test_reset_mid();
        alu = 32'h500; ld = 1'b1; f3 = F3Lw; sel = SelLoad; wr = 1'b1;
        dmem_if.dmem_ack = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (dmem_if.dmem_req !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_busy got req %b want 1", dmem_if.dmem_req);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (dmem_if.dmem_req !== 1'b0 || stall !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_drop got req %b stall %b want 0/0", dmem_if.dmem_req, stall);
        end
        set_nop();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            int          kind, ack_at, exp_busy;
            logic [31:0] a, v, p, im, rdv, exp_data;
            logic [4:0]  r;
            logic [1:0]  s;
            logic [3:0]  d;
            logic [2:0]  f;
            logic        l, w, acc, mal, to;
            kind = int'($urandom_range(0, 2));
            a = $urandom; v = $urandom; p = $urandom; im = $urandom; rdv = $urandom;
            r = 5'($urandom); f = 3'($urandom_range(0, 7)); w = 1'($urandom);
            ack_at = int'($urandom_range(0, MaxWait + 1));
            l = 1'b0; d = DweNone; s = SelAlu;
            case (kind)
                0: s = (int'($urandom_range(0, 2)) == 0) ? SelAlu :
                       (int'($urandom_range(0, 1)) == 0) ? SelPcImm : SelImm;
                1: begin l = 1'b1; s = SelLoad; end
                default: begin
                    d = (int'($urandom_range(0, 2)) == 0) ? DweB :
                        (int'($urandom_range(0, 1)) == 0) ? DweH : DweW;
                    w = 1'b0;
                end
            endcase
            acc = l || (d != 4'd0);
            mal = acc && ((a % ref_width(l, f, d)) != 0);
            to = acc && !mal && (ack_at < 1 || ack_at > int'(MaxWait));
            exp_busy = (!acc || mal) ? 0 : to ? int'(MaxWait) : ack_at;
            case (s)
                2'd0: exp_data = a;
                2'd1: exp_data = ref_load(rdv, a, f);
                2'd2: exp_data = p;
                default: exp_data = im;
            endcase
            exec(a, v, p, im, r, s, d, f, l, w, ack_at, rdv, 1'($urandom));
            n_cmp++;
            if (o_busy != exp_busy || o_stall != exp_busy) begin
                n_bad++;
                $display("FAIL rnd%0d_cycles got busy %0d stall %0d want %0d", i, o_busy,
                         o_stall, exp_busy);
            end
            n_cmp++;
            if (o_mis != int'(mal) || o_to != int'(to)) begin
                n_bad++;
                $display("FAIL rnd%0d_err got mis %0d to %0d want %b/%b", i, o_mis, o_to,
                         mal, to);
            end
            n_cmp++;
            if (o_wbw !== (w && !mal && !to) || o_wbr !== r) begin
                n_bad++;
                $display("FAIL rnd%0d_wbctl got wr %b rd %0d want %b/%0d", i, o_wbw, o_wbr,
                         w && !mal && !to, r);
            end
            if (!mal && !to) begin
                n_cmp++;
                if (o_wbd !== exp_data) begin
                    n_bad++;
                    $display("FAIL rnd%0d_data got %h want %h", i, o_wbd, exp_data);
                end
            end
            if (exp_busy > 0) begin
                n_cmp++;
                if (o_addr !== (a - (a % 4)) || o_we !== (d != 4'd0) || o_unstable != 0 ||
                    o_clear !== 1'b1) begin
                    n_bad++;
                    $display("FAIL rnd%0d_bus got addr %h we %b unstable %0d clear %b", i,
                             o_addr, o_we, o_unstable, o_clear);
                end
                if (d != 4'd0) begin
                    n_cmp++;
                    if (o_be !== 4'(int'(d) << (a % 4)) || o_wdata !== (v << (8 * (a % 4))))
                    begin
                        n_bad++;
                        $display("FAIL rnd%0d_store got be %b wdata %h want %b/%h", i, o_be,
                                 o_wdata, 4'(int'(d) << (a % 4)), v << (8 * (a % 4)));
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_lb_quick();
        test_lhu_slow();
        test_sh();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage access unit: consumes the EX/MEM pipeline-register outputs, runs loads and stores against the data memory over a req/ack handshake, and holds the pipeline with `stall` until each access completes. It performs byte-lane alignment for stores and extraction/extension for loads, selects the writeback value, and registers the result toward writeback, acting as the MEM/WB register.

## Interface
- `MAX_WAIT`, default 15: number of BUSY cycles without `dmem_ack` before the access is abandoned.
- `clk` in 1: clock. Reset is named `reset`: asynchronous, active-high.
- `reset` in 1: asynchronous, active-high.
- `mem_alu_out_in` in 32: ALU result / effective address.
- `mem_rv1_in` in 32: store data.
- `mem_pc_imm_in` in 32: PC+imm writeback source.
- `mem_imm_in` in 32: immediate writeback source.
- `mem_rd_in` in 5: destination register.
- `mem_reg_in_sel_in` in 2: writeback select. 00 ALU, 01 load data, 10 pc_imm, 11 imm.
- `mem_dwe_in` in 4: unshifted store mask. 0001 SB, 0011 SH, 1111 SW, 0000 no store.
- `mem_func3_in` in 3: load width/sign.
- `mem_mem_reg_in` in 1: load request.
- `mem_reg_wr_in` in 1: register write enable.
- `dmem_req` out 1: access request.
- `dmem_we` out 1: 1 for store.
- `dmem_addr` out 32: word-aligned address, {addr[31:2],2'b00}.
- `dmem_be` out 4: byte enables.
- `dmem_wdata` out 32: lane-aligned store data.
- `dmem_ack` in 1: access complete; `dmem_rdata` is valid in the same cycle.
- `dmem_rdata` in 32: read word.
- `stall` out 1: freezes PC, IF/ID, ID/EX, EX/MEM.
- `wb_data` out 32, `wb_rd` out 5, `wb_reg_wr` out 1: registered writeback.
- `misalign_err` out 1, `timeout_err` out 1: one-cycle error pulses.

## Operation
- Access condition: `mem_mem_reg_in` or `mem_dwe_in` ≠ 0. Any other instruction is a pass-through.
- Misalignment rules:
  - Halfword: `addr[0]` = 1.
  - Word: `addr[1:0]` ≠ 0.
  - Loads use `func3[1:0]` to determine width; stores use `dwe`.
- FSM IDLE/BUSY:
  - IDLE, aligned access → BUSY.
  - IDLE, misaligned access → stays IDLE; no request is issued.
  - BUSY, `dmem_ack` → IDLE.
  - BUSY, wait count reaches `MAX_WAIT` → IDLE with `timeout_err`.
- Request signals (`dmem_req`, `dmem_we`, `dmem_addr`, `dmem_be`, `dmem_wdata`) are registered at IDLE→BUSY. They are held stable until ack or timeout, then cleared to 0.
- Store alignment: `dmem_be` = `dwe` << `addr[1:0]`; `dmem_wdata` = `rv1` << (8·`addr[1:0]`).
- Load extraction: `sh` = `rdata` >> (8·`addr[1:0]`).
  - func3 000 LB: sign-extend `sh[7:0]`.
  - 001 LH: sign-extend `sh[15:0]`.
  - 100 LBU: zero-extend `sh[7:0]`.
  - 101 LHU: zero-extend `sh[15:0]`.
  - 010 LW, and all other codes: full word.
- Load data is taken from `dmem_rdata` in the ack cycle.
- `stall` (combinational):
  - 1 in IDLE with an aligned access.
  - 1 in BUSY without ack and before timeout.
  - 0 otherwise.
- WB register, updated every edge:
  - When `stall` = 0: loads `rd`, the selected data, and `reg_wr`.
  - `wb_reg_wr` is forced to 0 on a stalled cycle, on misalignment, and on timeout.
- Error pulses: `misalign_err` is 1 in the IDLE cycle of a misaligned access; `timeout_err` is 1 in the final BUSY cycle of a timed-out access. Neither is registered.

## Timing
- All registered outputs and state reset to 0 / IDLE.
- Reset asserted mid-access: `dmem_req` drops immediately and the access is abandoned.
- Pass-through: result appears on `wb_*` one edge after it is presented; no stall.
- Memory access, ack on first BUSY cycle: 2 cycles, with `stall` high 1 cycle.
- Memory access, ack on BUSY cycle N: `stall` high N cycles.
- At the ack edge, EX/MEM advances. The next instruction is therefore seen in IDLE, which rules out double issue.
- Wait counter: cleared on BUSY entry, incremented each BUSY cycle without ack.
- Ack and timeout in the same cycle: ack wins.
- `dmem_ack` while IDLE is ignored.

## Structure
- Shared package `mem_pkg` holds:
  - FSM state enum.
  - func3 constants LB/LH/LW/LBU/LHU.
  - `reg_in_sel` codes.
  - `dwe` mask constants.
- One sub-module, `mem_load_align`: combinational; inputs `rdata`, `addr[1:0]`, `func3`; output is the 32-bit extracted load value.

## Test plan
- **ALU pass-through:** `reg_in_sel` 00, `alu_out` 0x1234, `rd` 5, `reg_wr` 1 → next edge `wb_data` 0x1234, `wb_rd` 5, `wb_reg_wr` 1; `stall` never asserted.
- **LB, quick ack:** `addr` 0x103, `rdata` 0x80FF0000, ack on first BUSY cycle → `dmem_addr` 0x100, `wb_data` 0xFFFFFF80, `stall` high exactly 1 cycle.
- **LHU, slow ack:** `addr` 0x102, ack after 3 BUSY cycles, `rdata` 0xBEEF1234 → `wb_data` 0x0000BEEF, `stall` high 3 cycles, `dmem_*` stable throughout.
- **SH:** `addr` 0x202, `rv1` 0x0000ABCD, `dwe` 0011 → `dmem_be` 1100, `dmem_wdata` 0xABCD0000, `dmem_we` 1, `wb_reg_wr` 0.
- **Misaligned SW:** `addr` 0x301, `dwe` 1111 → no `dmem_req`, `misalign_err` 1 for 1 cycle, `wb_reg_wr` 0, no stall.
- **Timeout and reset:**
  - `MAX_WAIT` 4, no ack → `dmem_req` high 4 cycles, `timeout_err` pulse, `stall` low in the final BUSY cycle.
  - `reset` asserted while BUSY → `dmem_req` and `stall` 0 immediately.
